// File: rtl/dispatch_ctrl_pkg.sv
// Shared decode/dispatch definitions: reservation-station ids and the
// dispatch controller state encoding.
package dispatch_ctrl_pkg;

   localparam logic RS_0 = 1'b0;
   localparam logic RS_1 = 1'b1;

   typedef enum logic {
      DISP_RUN  = 1'b0,
      DISP_TRAP = 1'b1
   } disp_state_t;

endpackage

// File: rtl/dispatch_ctrl_credit_counter.sv
// Free-entry credit counter for one reservation station; saturates at DEPTH
// and flags a sticky overflow when a return arrives while already full.
module credit_counter #(
   parameter  int DEPTH = 4,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          reload,
   input  logic          dec,
   input  logic          inc,
   output logic [CW-1:0] count,
   output logic          overflow
);

   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   // reload also masks inc, so a return in a flush cycle cannot raise overflow
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count    <= FULL;
         overflow <= 1'b0;
      end else if (reload) begin
         count <= FULL;
      end else if (inc && !dec) begin
         if (count == FULL) overflow <= 1'b1;
         else               count    <= count + 1'b1;
      end else if (dec && !inc) begin
         count <= count - 1'b1;
      end
   end

endmodule

// File: rtl/dispatch_ctrl.sv
// Steers decoded ops to RS_0/RS_1 under credit flow control and diverts
// illegal ops into a trap handshake.
//
//   state     | meaning
//   DISP_RUN  | accepting ops, dispatching legal ones to their station
//   DISP_TRAP | illegal op captured, trap_req held until trap_ack
module dispatch_ctrl
   import dispatch_ctrl_pkg::*;
#(
   parameter int PAYLOAD_W = 64,
   parameter int RS0_DEPTH = 4,
   parameter int RS1_DEPTH = 4
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           flush,
   input  logic                           dec_valid,
   output logic                           dec_ready,
   input  logic                           dec_rs_id,
   input  logic                           dec_illegal,
   input  logic [PAYLOAD_W-1:0]           dec_payload,
   output logic                           rs0_disp_valid,
   output logic                           rs1_disp_valid,
   output logic [PAYLOAD_W-1:0]           disp_payload,
   input  logic                           rs0_credit_ret,
   input  logic                           rs1_credit_ret,
   output logic [$clog2(RS0_DEPTH+1)-1:0] rs0_credits,
   output logic [$clog2(RS1_DEPTH+1)-1:0] rs1_credits,
   output logic                           trap_req,
   input  logic                           trap_ack,
   output logic                           credit_err
);

   disp_state_t state, state_next;
   logic        credit_avail;
   logic        accept;
   logic        legal_accept;
   logic        disp0;
   logic        disp1;
   logic        ovf0;
   logic        ovf1;

   assign credit_avail = (dec_rs_id == RS_1) ? (rs1_credits != '0) : (rs0_credits != '0);
   assign dec_ready    = (state == DISP_RUN) && !flush && (dec_illegal || credit_avail);
   assign accept       = dec_valid && dec_ready;
   assign legal_accept = accept && !dec_illegal;
   assign disp0        = legal_accept && (dec_rs_id == RS_0);
   assign disp1        = legal_accept && (dec_rs_id == RS_1);

   assign trap_req   = (state == DISP_TRAP);
   assign credit_err = ovf0 || ovf1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= DISP_RUN;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      if (flush) begin
         state_next = DISP_RUN;
      end else begin
         unique case (state)
            DISP_RUN:  if (accept && dec_illegal) state_next = DISP_TRAP;
            DISP_TRAP: if (trap_ack)              state_next = DISP_RUN;
            default:                              state_next = DISP_RUN;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rs0_disp_valid <= 1'b0;
         rs1_disp_valid <= 1'b0;
         disp_payload   <= '0;
      end else if (flush) begin
         rs0_disp_valid <= 1'b0;
         rs1_disp_valid <= 1'b0;
      end else begin
         rs0_disp_valid <= disp0;
         rs1_disp_valid <= disp1;
         if (legal_accept) disp_payload <= dec_payload;
      end
   end

   credit_counter #(.DEPTH(RS0_DEPTH)) u_rs0_credits (
      .clk      (clk),
      .rst_n    (rst_n),
      .reload   (flush),
      .dec      (disp0),
      .inc      (rs0_credit_ret),
      .count    (rs0_credits),
      .overflow (ovf0)
   );

   credit_counter #(.DEPTH(RS1_DEPTH)) u_rs1_credits (
      .clk      (clk),
      .rst_n    (rst_n),
      .reload   (flush),
      .dec      (disp1),
      .inc      (rs1_credit_ret),
      .count    (rs1_credits),
      .overflow (ovf1)
   );

endmodule

// File: tb/tb_dispatch_ctrl.sv
// Self-checking bench for dispatch_ctrl: directed scenarios plus a randomized
// run, all compared against a credit/trap reference model kept here.
module tb_dispatch_ctrl;

   localparam int PW = 64;
   localparam int D0 = 4;
   localparam int D1 = 4;

   logic          clk;
   logic          rst_n;
   logic          flush;
   logic          dec_valid;
   logic          dec_ready;
   logic          dec_rs_id;
   logic          dec_illegal;
   logic [PW-1:0] dec_payload;
   logic          rs0_disp_valid;
   logic          rs1_disp_valid;
   logic [PW-1:0] disp_payload;
   logic          rs0_credit_ret;
   logic          rs1_credit_ret;
   logic [2:0]    rs0_credits;
   logic [2:0]    rs1_credits;
   logic          trap_req;
   logic          trap_ack;
   logic          credit_err;

   int checks = 0;
   int errors = 0;

   // reference model state
   int            m_c0, m_c1;
   bit            m_trap, m_err, m_s0, m_s1;
   logic [PW-1:0] m_pay;

   dispatch_ctrl #(.PAYLOAD_W(PW), .RS0_DEPTH(D0), .RS1_DEPTH(D1)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .flush          (flush),
      .dec_valid      (dec_valid),
      .dec_ready      (dec_ready),
      .dec_rs_id      (dec_rs_id),
      .dec_illegal    (dec_illegal),
      .dec_payload    (dec_payload),
      .rs0_disp_valid (rs0_disp_valid),
      .rs1_disp_valid (rs1_disp_valid),
      .disp_payload   (disp_payload),
      .rs0_credit_ret (rs0_credit_ret),
      .rs1_credit_ret (rs1_credit_ret),
      .rs0_credits    (rs0_credits),
      .rs1_credits    (rs1_credits),
      .trap_req       (trap_req),
      .trap_ack       (trap_ack),
      .credit_err     (credit_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_c0 = D0; m_c1 = D1; m_trap = 0; m_err = 0; m_s0 = 0; m_s1 = 0; m_pay = '0;
   endtask

   function automatic bit model_ready();
      return !m_trap && !flush && (dec_illegal || (dec_rs_id ? (m_c1 > 0) : (m_c0 > 0)));
   endfunction

   task automatic drive(input logic v, input logic rs, input logic ill, input logic [PW-1:0] pay,
                        input logic r0, input logic r1, input logic ack, input logic fl);
      dec_valid = v; dec_rs_id = rs; dec_illegal = ill; dec_payload = pay;
      rs0_credit_ret = r0; rs1_credit_ret = r1; trap_ack = ack; flush = fl;
   endtask

   // advance one clock: update the model from the inputs applied this cycle
   task automatic tick();
      bit acc, legal, d0, d1;
      acc   = dec_valid && model_ready();
      legal = acc && !dec_illegal;
      d0    = legal && (dec_rs_id == 1'b0);
      d1    = legal && (dec_rs_id == 1'b1);
      if (flush) begin
         m_s0 = 0; m_s1 = 0; m_c0 = D0; m_c1 = D1; m_trap = 0;
      end else begin
         m_s0 = d0; m_s1 = d1;
         if (legal) m_pay = dec_payload;
         if (m_trap) begin
            if (trap_ack) m_trap = 0;
         end else if (acc && dec_illegal) begin
            m_trap = 1;
         end
         if (rs0_credit_ret && !d0) begin
            if (m_c0 == D0) m_err = 1; else m_c0 = m_c0 + 1;
         end else if (d0 && !rs0_credit_ret) m_c0 = m_c0 - 1;
         if (rs1_credit_ret && !d1) begin
            if (m_c1 == D1) m_err = 1; else m_c1 = m_c1 + 1;
         end else if (d1 && !rs1_credit_ret) m_c1 = m_c1 - 1;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic test_reset();
      drive(1, 0, 0, 64'h0, 0, 0, 0, 0);
      #1;
      checks++; if (rs0_disp_valid !== 1'b0 || rs1_disp_valid !== 1'b0) begin errors++; $display("FAIL reset_strobes got %b%b exp 00", rs0_disp_valid, rs1_disp_valid); end
      checks++; if (disp_payload !== '0) begin errors++; $display("FAIL reset_payload got %h exp 0", disp_payload); end
      checks++; if (rs0_credits !== 3'd4 || rs1_credits !== 3'd4) begin errors++; $display("FAIL reset_credits got %0d/%0d exp 4/4", rs0_credits, rs1_credits); end
      checks++; if (trap_req !== 1'b0 || credit_err !== 1'b0) begin errors++; $display("FAIL reset_trap_err got %b/%b exp 0/0", trap_req, credit_err); end
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %b exp 1", dec_ready); end
      drive(0, 0, 0, 64'h0, 0, 0, 0, 0);
   endtask

   task automatic test_fill_rs0();
      for (int i = 0; i < 4; i++) begin
         drive(1, 0, 0, 64'(100 + i), 0, 0, 0, 0);
         #1;
         checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL fill_ready[%0d] got %b exp 1", i, dec_ready); end
         tick();
         checks++; if (rs0_disp_valid !== 1'b1 || rs1_disp_valid !== 1'b0) begin errors++; $display("FAIL fill_strobe[%0d] got %b%b exp 10", i, rs0_disp_valid, rs1_disp_valid); end
         checks++; if (disp_payload !== 64'(100 + i)) begin errors++; $display("FAIL fill_payload[%0d] got %0d exp %0d", i, disp_payload, 100 + i); end
         checks++; if (rs0_credits !== 3'(3 - i)) begin errors++; $display("FAIL fill_credits[%0d] got %0d exp %0d", i, rs0_credits, 3 - i); end
      end
      drive(1, 0, 0, 64'd200, 0, 0, 0, 0);
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL full_stall got %b exp 0", dec_ready); end
      tick();
      checks++; if (rs0_disp_valid !== 1'b0 || rs0_credits !== 3'd0) begin errors++; $display("FAIL full_hold got strobe %b cr %0d exp 0 0", rs0_disp_valid, rs0_credits); end
      drive(1, 0, 0, 64'd200, 1, 0, 0, 0);
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL ret_cycle_ready got %b exp 0", dec_ready); end
      tick();
      checks++; if (rs0_credits !== 3'd1 || rs0_disp_valid !== 1'b0) begin errors++; $display("FAIL ret_credit got cr %0d strobe %b exp 1 0", rs0_credits, rs0_disp_valid); end
      drive(1, 0, 0, 64'd200, 0, 0, 0, 0);
      #1;
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL ret_ready got %b exp 1", dec_ready); end
      tick();
      checks++; if (rs0_disp_valid !== 1'b1 || disp_payload !== 64'd200 || rs0_credits !== 3'd0) begin errors++; $display("FAIL fifth_dispatch got strobe %b pay %0d cr %0d exp 1 200 0", rs0_disp_valid, disp_payload, rs0_credits); end
   endtask

   task automatic test_alternate();
      drive(0, 0, 0, 64'h0, 0, 0, 0, 1);
      tick();
      for (int i = 0; i < 4; i++) begin
         drive(1, 1'(i % 2), 0, 64'(i), 0, 0, 0, 0);
         #1;
         checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL alt_ready[%0d] got %b exp 1", i, dec_ready); end
         tick();
         checks++; if (rs0_disp_valid !== 1'(i % 2 == 0) || rs1_disp_valid !== 1'(i % 2 == 1)) begin errors++; $display("FAIL alt_strobe[%0d] got %b%b exp %b%b", i, rs0_disp_valid, rs1_disp_valid, 1'(i % 2 == 0), 1'(i % 2 == 1)); end
         checks++; if (disp_payload !== 64'(i)) begin errors++; $display("FAIL alt_payload[%0d] got %0d exp %0d", i, disp_payload, i); end
      end
      checks++; if (rs0_credits !== 3'd2 || rs1_credits !== 3'd2) begin errors++; $display("FAIL alt_credits got %0d/%0d exp 2/2", rs0_credits, rs1_credits); end
   endtask

   task automatic test_simul_accept_return();
      drive(1, 0, 0, 64'd55, 0, 0, 0, 0);
      tick();
      drive(1, 0, 0, 64'd66, 1, 0, 0, 0);
      #1;
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL simul_ready got %b exp 1", dec_ready); end
      tick();
      checks++; if (rs0_disp_valid !== 1'b1 || disp_payload !== 64'd66) begin errors++; $display("FAIL simul_dispatch got %b %0d exp 1 66", rs0_disp_valid, disp_payload); end
      checks++; if (rs0_credits !== 3'd1) begin errors++; $display("FAIL simul_credits got %0d exp 1", rs0_credits); end
   endtask

   task automatic test_illegal_trap();
      drive(1, 0, 0, 64'd70, 0, 0, 0, 0);
      tick();
      drive(1, 0, 1, 64'd77, 0, 0, 0, 0);
      #1;
      checks++; if (dec_ready !== 1'b1) begin errors++; $display("FAIL illegal_ready got %b exp 1", dec_ready); end
      tick();
      checks++; if (rs0_disp_valid !== 1'b0 || rs1_disp_valid !== 1'b0) begin errors++; $display("FAIL illegal_no_strobe got %b%b exp 00", rs0_disp_valid, rs1_disp_valid); end
      checks++; if (trap_req !== 1'b1) begin errors++; $display("FAIL illegal_trap got %b exp 1", trap_req); end
      checks++; if (disp_payload !== m_pay) begin errors++; $display("FAIL illegal_payload_hold got %0d exp %0d", disp_payload, m_pay); end
      for (int i = 0; i < 3; i++) begin
         drive(1, 1, 0, 64'd88, 0, 0, 0, 0);
         #1;
         checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL trap_ready[%0d] got %b exp 0", i, dec_ready); end
         tick();
         checks++; if (trap_req !== 1'b1 || rs1_disp_valid !== 1'b0) begin errors++; $display("FAIL trap_hold[%0d] got req %b strobe %b exp 1 0", i, trap_req, rs1_disp_valid); end
      end
      drive(0, 0, 0, 64'h0, 0, 0, 1, 0);
      tick();
      checks++; if (trap_req !== 1'b0) begin errors++; $display("FAIL trap_ack got %b exp 0", trap_req); end
      checks++; if (rs0_credits !== 3'd0 || rs1_credits !== 3'd2) begin errors++; $display("FAIL trap_credits got %0d/%0d exp 0/2", rs0_credits, rs1_credits); end
      drive(0, 0, 0, 64'h0, 0, 0, 1, 0);
      tick();
      drive(1, 1, 0, 64'd88, 0, 0, 0, 0);
      #1;
      checks++; if (dec_ready !== 1'b1 || trap_req !== 1'b0) begin errors++; $display("FAIL run_after_ack got ready %b req %b exp 1 0", dec_ready, trap_req); end
      drive(0, 0, 0, 64'h0, 0, 0, 0, 0);
   endtask

   task automatic test_flush();
      drive(0, 0, 0, 64'h0, 1, 0, 0, 0);
      tick();
      checks++; if (rs0_credits !== 3'd1 || rs1_credits !== 3'd2) begin errors++; $display("FAIL preflush_credits got %0d/%0d exp 1/2", rs0_credits, rs1_credits); end
      drive(1, 1, 0, 64'd99, 1, 1, 0, 1);
      #1;
      checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", dec_ready); end
      tick();
      checks++; if (rs0_disp_valid !== 1'b0 || rs1_disp_valid !== 1'b0) begin errors++; $display("FAIL flush_strobe got %b%b exp 00", rs0_disp_valid, rs1_disp_valid); end
      checks++; if (rs0_credits !== 3'd4 || rs1_credits !== 3'd4) begin errors++; $display("FAIL flush_credits got %0d/%0d exp 4/4", rs0_credits, rs1_credits); end
      checks++; if (disp_payload !== m_pay || credit_err !== 1'b0) begin errors++; $display("FAIL flush_payload_err got %0d/%b exp %0d/0", disp_payload, credit_err, m_pay); end
   endtask

   task automatic test_credit_err();
      drive(0, 0, 0, 64'h0, 0, 1, 0, 0);
      tick();
      checks++; if (rs1_credits !== 3'd4 || credit_err !== 1'b1) begin errors++; $display("FAIL overflow got cr %0d err %b exp 4 1", rs1_credits, credit_err); end
      drive(0, 0, 0, 64'h0, 0, 0, 0, 1);
      tick();
      checks++; if (credit_err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b exp 1", credit_err); end
      drive(0, 0, 0, 64'h0, 0, 0, 0, 0);
      tick();
   endtask

   task automatic test_random();
      bit hold = 0;
      for (int n = 0; n < 600; n++) begin
         if (!hold) begin
            dec_valid   = ($urandom_range(0, 3) != 0);
            dec_rs_id   = 1'($urandom_range(0, 1));
            dec_illegal = ($urandom_range(0, 9) == 0);
            dec_payload = {$urandom, $urandom};
         end
         rs0_credit_ret = (m_c0 < D0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
         rs1_credit_ret = (m_c1 < D1) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 40) == 0);
         trap_ack       = ($urandom_range(0, 2) == 0);
         flush          = ($urandom_range(0, 30) == 0);
         #1;
         checks++; if (dec_ready !== model_ready()) begin errors++; $display("FAIL rnd_ready[%0d] got %b exp %b", n, dec_ready, model_ready()); end
         hold = dec_valid && !model_ready() && !flush;
         tick();
         checks++; if (rs0_disp_valid !== m_s0 || rs1_disp_valid !== m_s1) begin errors++; $display("FAIL rnd_strobe[%0d] got %b%b exp %b%b", n, rs0_disp_valid, rs1_disp_valid, m_s0, m_s1); end
         checks++; if (disp_payload !== m_pay) begin errors++; $display("FAIL rnd_payload[%0d] got %h exp %h", n, disp_payload, m_pay); end
         checks++; if (rs0_credits !== 3'(m_c0) || rs1_credits !== 3'(m_c1)) begin errors++; $display("FAIL rnd_credits[%0d] got %0d/%0d exp %0d/%0d", n, rs0_credits, rs1_credits, m_c0, m_c1); end
         checks++; if (trap_req !== m_trap || credit_err !== m_err) begin errors++; $display("FAIL rnd_trap_err[%0d] got %b/%b exp %b/%b", n, trap_req, credit_err, m_trap, m_err); end
      end
      drive(0, 0, 0, 64'h0, 0, 0, 0, 0);
   endtask

   task automatic test_async_reset();
      drive(0, 0, 0, 64'h0, 0, 1, 0, 1);
      tick();
      drive(0, 0, 0, 64'h0, 0, 1, 0, 0);
      tick();
      drive(1, 0, 0, 64'hDEAD, 0, 0, 0, 0);
      tick();
      checks++; if (rs0_disp_valid !== 1'b1 || credit_err !== 1'b1) begin errors++; $display("FAIL pre_reset got strobe %b err %b exp 1 1", rs0_disp_valid, credit_err); end
      drive(1, 0, 1, 64'h0, 0, 0, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++; if (rs0_disp_valid !== 1'b0 || disp_payload !== '0) begin errors++; $display("FAIL async_strobe_pay got %b %h exp 0 0", rs0_disp_valid, disp_payload); end
      checks++; if (rs0_credits !== 3'd4 || rs1_credits !== 3'd4) begin errors++; $display("FAIL async_credits got %0d/%0d exp 4/4", rs0_credits, rs1_credits); end
      checks++; if (credit_err !== 1'b0 || trap_req !== 1'b0) begin errors++; $display("FAIL async_err_trap got %b/%b exp 0/0", credit_err, trap_req); end
      drive(0, 0, 0, 64'h0, 0, 0, 0, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      @(negedge clk);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(0, 0, 0, 64'h0, 0, 0, 0, 0);
      model_reset();
      #12;
      rst_n = 1'b1;
      @(negedge clk);
      test_reset();
      test_fill_rs0();
      test_alternate();
      test_simul_accept_return();
      test_illegal_trap();
      test_flush();
      test_credit_err();
      test_random();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
